// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Handshake and data bundle for the bit-serial subtractor.
//   start      : request, honoured only while the subtractor is idle
//   A, B, Bin  : minuend, subtrahend, borrow-in (captured on acceptance)
//   busy       : subtraction in progress
//   done       : one-cycle pulse when Diff/Bout/V are updated
//   Diff, Bout : difference modulo 2^WIDTH and final borrow-out
//   V          : two's-complement overflow of the subtraction
// Modports: master drives the request side, slave is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout, V
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, one bit per clock,
// LSB first, through a single full-subtractor cell and shift registers.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_subtractor_if.slave (start/A/B/Bin in, busy/done/Diff/Bout/V out)
// A request accepted at edge k is processed on edges k+1..k+WIDTH; results
// and the done pulse appear after edge k+WIDTH, and the FSM is back in IDLE
// in that same cycle, so a new start can be accepted while done is high.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    // Only WIDTH-1 partial bits need storing: the final bit goes straight
    // from the cell into Diff on the completion edge.
    logic [WIDTH-2:0] res_sr_reg;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             done_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             v_reg;

    // Full-subtractor cell and derived next values
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             borrow_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        bit_a       = a_sr_reg[0];
        bit_b       = b_sr_reg[0];
        bit_d       = bit_a ^ bit_b ^ borrow_reg;
        borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_reg);
        res_next    = {bit_d, res_sr_reg};
        last_bit    = (cnt_reg == CW'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            v_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sr_reg   <= bus.A;
                        b_sr_reg   <= bus.B;
                        borrow_reg <= bus.Bin;
                        cnt_reg    <= '0;
                        a_msb_reg  <= bus.A[WIDTH-1];
                        b_msb_reg  <= bus.B[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    res_sr_reg <= res_next[WIDTH-1:1];
                    borrow_reg <= borrow_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        diff_reg <= res_next;
                        bout_reg <= borrow_next;
                        // Overflow only possible when operand signs differ and
                        // the result sign departs from the minuend's.
                        v_reg    <= (a_msb_reg != b_msb_reg) && (bit_d != a_msb_reg);
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.Diff = diff_reg;
    assign bus.Bout = bout_reg;
    assign bus.V    = v_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int WIDTH = 4;
    localparam int MAXW  = 40;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands
    function automatic int ref_diff(input int a, input int b, input int bin);
        return (a - b - bin) & ((1 << WIDTH) - 1);
    endfunction

    function automatic int ref_bout(input int a, input int b, input int bin);
        return (a < b + bin) ? 1 : 0;
    endfunction

    function automatic int ref_v(input int a, input int b, input int bin);
        int sa, sb, r;
        sa = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
        sb = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
        r  = sa - sb - bin;
        return (r < -(1 << (WIDTH - 1)) || r > (1 << (WIDTH - 1)) - 1) ? 1 : 0;
    endfunction

    // Wait (at negedges) for done; returns cycles waited and busy cycles seen.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cyc < MAXW) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input int a, input int b, input int bin);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_diff"}, 32'(bus.Diff), 32'(ref_diff(a, b, bin)));
        check({tag, "_bout"}, 32'(bus.Bout), 32'(ref_bout(a, b, bin)));
        check({tag, "_v"},    32'(bus.V),    32'(ref_v(a, b, bin)));
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Full operation: start, latency and busy-width checks, results, done width
    task automatic run_op(input string tag, input int a, input int b, input int bin);
        int cyc, bc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = WIDTH'(a);
        bus.B     = WIDTH'(b);
        bus.Bin   = bin[0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        wait_done(cyc, bc);
        check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
        check({tag, "_busycyc"}, 32'(bc), 32'(WIDTH));
        check_result(tag, a, b, bin);
        $display("op %s: A=%0d B=%0d Bin=%0d -> Diff=%0d Bout=%0d V=%0d", tag, a, b, bin,
                 bus.Diff, bus.Bout, bus.V);
        @(negedge clk);
        check({tag, "_donewidth"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int cyc, bc, dcount;
        int ra, rb, rbin;
        checks = 0;
        errors = 0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.Diff), 32'd0);
        check("rst_bout", 32'(bus.Bout), 32'd0);
        check("rst_v",    32'(bus.V),    32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_done", 32'(bus.done), 32'd0);
        end

        // Directed operations
        run_op("d7m3",   7, 3, 0);
        run_op("d3m5",   3, 5, 0);
        run_op("d0m0b1", 0, 0, 1);
        run_op("d8m1",   8, 1, 0);
        run_op("d4m5b1", 4, 5, 1);

        // Start pulses during busy are ignored
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd9; bus.B = 4'd2; bus.Bin = 1'b0;
        @(negedge clk);
        bus.A = 4'd1; bus.B = 4'd1;     // start still high while busy
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc, bc);
        check("ign_latency", 32'(cyc), 32'(WIDTH - 3));
        check_result("ign", 9, 2, 0);
        $display("op ign: A=9 B=2 with start during busy -> Diff=%0d", bus.Diff);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        check("ign_onedone", 32'(dcount), 32'd0);

        // Start held on the done cycle is accepted immediately
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd5; bus.B = 4'd2; bus.Bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc, bc);
        check_result("b2b1", 5, 2, 0);
        bus.start = 1'b1; bus.A = 4'd10; bus.B = 4'd3; bus.Bin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(cyc, bc);
        check("b2b_latency", 32'(cyc), 32'(WIDTH));
        check_result("b2b2", 10, 3, 1);
        $display("op b2b: A=10 B=3 Bin=1 -> Diff=%0d Bout=%0d V=%0d", bus.Diff, bus.Bout, bus.V);

        // Reset in the middle of a run
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd13; bus.B = 4'd2; bus.Bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_diff", 32'(bus.Diff), 32'd0);
        check("mid_rst_bout", 32'(bus.Bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        check("mid_rst_nodone", 32'(dcount), 32'd0);
        check("mid_rst_diff_hold", 32'(bus.Diff), 32'd0);
        run_op("d6m6", 6, 6, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            ra   = int'($urandom_range((1 << WIDTH) - 1, 0));
            rb   = int'($urandom_range((1 << WIDTH) - 1, 0));
            rbin = int'($urandom_range(1, 0));
            run_op("rnd", ra, rb, rbin);
            // Results must hold while idle
            @(negedge clk);
            check("rnd_hold", 32'(bus.Diff), 32'(ref_diff(ra, rb, rbin)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
